// File: rtl/pakout_pkg.sv
// Shared types and sizing for the pakout packet serializer.
// The redundancy fold lives in pakout_red so the receive side can reuse it.
package pakout_pkg;

    localparam int PSZ      = 2;
    localparam int ASZ      = 6;
    localparam int DSZ      = 8;
    localparam int RSZ      = 4;
    localparam int MIN_ADDR = 1;
    localparam int MAX_ADDR = 14;
    localparam int IDXW     = $clog2(PSZ + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IN_REL,
        S_OUT_REQ,
        S_OUT_REL
    } pak_state_t;

endpackage

// File: rtl/pakout_if.sv
// 4-phase req/ack channels: whole-packet receive side and pakio beat send side.
interface pakout_rcv_if;
    import pakout_pkg::*;

    logic [ASZ-1:0]     addr;
    logic [PSZ*DSZ-1:0] dat;
    logic               req;
    logic               ack;

    modport master (output addr, dat, req, input ack);
    modport slave  (input addr, dat, req, output ack);
endinterface

interface pakout_snd_if;
    import pakout_pkg::*;

    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
    logic           is_addr;
    logic           last;
    logic           req;
    logic           ack;

    modport master (output dat, red, is_addr, last, req, input ack);
    modport slave  (input dat, red, is_addr, last, req, output ack);
endinterface

// File: rtl/pakout_red.sv
// XOR fold of a DSZ-bit word into one RSZ-bit redundancy field.
module pakout_red #(
    parameter int DSZ = 8,
    parameter int RSZ = 4
) (
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red
);

    always_comb begin
        red = '0;
        for (int i = 0; i < DSZ / RSZ; i++) begin
            red = red ^ dat[i*RSZ +: RSZ];
        end
    end

endmodule

// File: rtl/pakout.sv
// Packet serializer: captures one packet, then emits address beat plus PSZ data beats.
//
// state     | meaning
// S_IDLE    | ready, waiting for upstream req
// S_IN_REL  | packet latched, waiting for upstream req to fall; range check
// S_OUT_REQ | beat idx driven, snd0.req high, waiting for ack
// S_OUT_REL | snd0.req low, waiting for ack to fall; advance or finish
module pakout
    import pakout_pkg::*;
(
    input  logic          i_clk,
    input  logic          reset,
    output logic          ready,
    pakout_rcv_if.slave   rcv0,
    pakout_snd_if.master  snd0,
    output logic [7:0]    err_cnt
);

    pak_state_t         state;
    logic [IDXW-1:0]    idx;
    logic [ASZ-1:0]     addr_q;
    logic [PSZ*DSZ-1:0] pkt_q;
    logic [DSZ-1:0]     beat_dat;
    logic [RSZ-1:0]     beat_red;
    logic               addr_ok;

    assign addr_ok = (addr_q >= ASZ'(MIN_ADDR)) && (addr_q <= ASZ'(MAX_ADDR));

    // Beat 0 carries the address, beat k carries word k-1.
    always_comb begin
        beat_dat = DSZ'(addr_q);
        for (int k = 0; k < PSZ; k++) begin
            if (idx == IDXW'(k + 1)) begin
                beat_dat = pkt_q[k*DSZ +: DSZ];
            end
        end
    end

    pakout_red #(.DSZ(DSZ), .RSZ(RSZ)) u_red (
        .dat (beat_dat),
        .red (beat_red)
    );

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            addr_q       <= '0;
            pkt_q        <= '0;
            ready        <= 1'b1;
            rcv0.ack     <= 1'b0;
            snd0.dat     <= '0;
            snd0.red     <= '0;
            snd0.is_addr <= 1'b0;
            snd0.last    <= 1'b0;
            snd0.req     <= 1'b0;
            err_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rcv0.req) begin
                        addr_q   <= rcv0.addr;
                        pkt_q    <= rcv0.dat;
                        rcv0.ack <= 1'b1;
                        ready    <= 1'b0;
                        state    <= S_IN_REL;
                    end
                end
                S_IN_REL: begin
                    if (!rcv0.req) begin
                        rcv0.ack <= 1'b0;
                        if (addr_ok) begin
                            idx   <= '0;
                            state <= S_OUT_REQ;
                        end else begin
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                            ready <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_OUT_REQ: begin
                    if (!snd0.req) begin
                        snd0.dat     <= beat_dat;
                        snd0.red     <= beat_red;
                        snd0.is_addr <= (idx == '0);
                        snd0.last    <= (idx == IDXW'(PSZ));
                        snd0.req     <= 1'b1;
                    end else if (snd0.ack) begin
                        snd0.req <= 1'b0;
                        state    <= S_OUT_REL;
                    end
                end
                S_OUT_REL: begin
                    if (!snd0.ack) begin
                        if (idx == IDXW'(PSZ)) begin
                            snd0.is_addr <= 1'b0;
                            snd0.last    <= 1'b0;
                            ready        <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_OUT_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pakout.sv
// Self-checking bench for pakout against a packet-level beat model.
module tb_pakout;
    import pakout_pkg::*;

    logic       i_clk = 1'b0;
    logic       reset;
    logic       ready;
    logic [7:0] err_cnt;

    pakout_rcv_if rcv0();
    pakout_snd_if snd0();

    pakout dut (
        .i_clk   (i_clk),
        .reset   (reset),
        .ready   (ready),
        .rcv0    (rcv0),
        .snd0    (snd0),
        .err_cnt (err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;
    int rises       = 0;
    int exp_err     = 0;

    always @(posedge snd0.req) rises++;

    function automatic logic [3:0] fold(input logic [7:0] d);
        int hi, lo;
        hi = int'(d) / 16;
        lo = int'(d) % 16;
        return 4'(hi ^ lo);
    endfunction

    function automatic bit legal(input logic [5:0] a);
        return (int'(a) >= 1) && (int'(a) <= 14);
    endfunction

    task automatic send_pkt(input logic [5:0] a, input logic [15:0] d, input int hold);
        int n;
        rcv0.addr = a;
        rcv0.dat  = d;
        rcv0.req  = 1'b1;
        n = 0;
        while (!rcv0.ack && n < 50) begin @(negedge i_clk); n++; end
        vectors++;
        if (rcv0.ack !== 1'b1) begin
            miscompares++;
            $display("FAIL rcv_ack_rise got %b want 1", rcv0.ack);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clk);
            vectors++;
            if (rcv0.ack !== 1'b1 || ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rcv_ack_hold cyc %0d got ack=%b ready=%b want ack=1 ready=0", i, rcv0.ack, ready);
            end
        end
        rcv0.req = 1'b0;
        n = 0;
        while (rcv0.ack && n < 50) begin @(negedge i_clk); n++; end
        vectors++;
        if (rcv0.ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rcv_ack_fall got %b want 0", rcv0.ack);
        end
        if (!legal(a) && exp_err < 255) exp_err++;
    endtask

    task automatic expect_packet(input logic [5:0] a, input logic [15:0] d, input int dly);
        int n;
        logic [7:0] ed;
        for (int k = 0; k <= PSZ; k++) begin
            ed = (k == 0) ? {2'b00, a} : d[(k-1)*8 +: 8];
            n = 0;
            while (!snd0.req && n < 50) begin @(negedge i_clk); n++; end
            vectors++;
            if (snd0.req !== 1'b1) begin
                miscompares++;
                $display("FAIL beat%0d_req_timeout got %b want 1", k, snd0.req);
                return;
            end
            vectors++;
            if (snd0.dat !== ed || snd0.red !== fold(ed)) begin
                miscompares++;
                $display("FAIL beat%0d_data got dat=%h red=%h want dat=%h red=%h", k, snd0.dat, snd0.red, ed, fold(ed));
            end
            vectors++;
            if (snd0.is_addr !== (k == 0) || snd0.last !== (k == PSZ)) begin
                miscompares++;
                $display("FAIL beat%0d_flags got is_addr=%b last=%b want is_addr=%b last=%b",
                         k, snd0.is_addr, snd0.last, (k == 0), (k == PSZ));
            end
            for (int i = 0; i < dly; i++) begin
                @(negedge i_clk);
                vectors++;
                if (snd0.req !== 1'b1 || snd0.dat !== ed || snd0.red !== fold(ed)) begin
                    miscompares++;
                    $display("FAIL beat%0d_stable cyc %0d got req=%b dat=%h red=%h want req=1 dat=%h red=%h",
                             k, i, snd0.req, snd0.dat, snd0.red, ed, fold(ed));
                end
            end
            snd0.ack = 1'b1;
            n = 0;
            while (snd0.req && n < 50) begin @(negedge i_clk); n++; end
            vectors++;
            if (snd0.req !== 1'b0) begin
                miscompares++;
                $display("FAIL beat%0d_req_fall got %b want 0", k, snd0.req);
            end
            snd0.ack = 1'b0;
        end
        @(negedge i_clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_return got %b want 1", ready);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if (ready !== 1'b1 || rcv0.ack !== 1'b0 || snd0.req !== 1'b0 || snd0.dat !== 8'h00 ||
            snd0.red !== 4'h0 || snd0.is_addr !== 1'b0 || snd0.last !== 1'b0 || err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL %s got ready=%b ack=%b req=%b dat=%h red=%h is_addr=%b last=%b err=%0d want 1,0,0,00,0,0,0,0",
                     tag, ready, rcv0.ack, snd0.req, snd0.dat, snd0.red, snd0.is_addr, snd0.last, err_cnt);
        end
    endtask

    task automatic check_err(input string tag);
        vectors++;
        if (err_cnt !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL %s err_cnt got %0d want %0d", tag, err_cnt, exp_err);
        end
    endtask

    task automatic check_rises(input string tag, input int r0, input int want);
        vectors++;
        if (rises - r0 !== want) begin
            miscompares++;
            $display("FAIL %s snd_req_pulses got %0d want %0d", tag, rises - r0, want);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        rcv0.req  = 1'b0;
        rcv0.addr = '0;
        rcv0.dat  = '0;
        snd0.ack  = 1'b0;
        repeat (2) @(negedge i_clk);
        check_idle_outputs("reset_state");
        reset   = 1'b1;
        exp_err = 0;
        @(negedge i_clk);
    endtask

    task automatic test_legal();
        int r0;
        r0 = rises;
        send_pkt(6'd5, 16'hA13C, 0);
        @(negedge i_clk);
        vectors++;
        if (snd0.req !== 1'b1) begin
            miscompares++;
            $display("FAIL min_latency snd_req got %b want 1", snd0.req);
        end
        expect_packet(6'd5, 16'hA13C, 1);
        check_rises("legal", r0, 3);
    endtask

    task automatic test_out_of_range();
        int r0;
        r0 = rises;
        send_pkt(6'd0, 16'h1234, 0);
        repeat (4) @(negedge i_clk);
        send_pkt(6'd15, 16'h5678, 0);
        repeat (4) @(negedge i_clk);
        check_rises("out_of_range", r0, 0);
        check_err("out_of_range");
        vectors++;
        if (err_cnt !== 8'd2 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL out_of_range_abs got err=%0d ready=%b want err=2 ready=1", err_cnt, ready);
        end
    endtask

    task automatic test_boundary();
        int r0;
        r0 = rises;
        send_pkt(6'd1, 16'h0F0E, 0);
        expect_packet(6'd1, 16'h0F0E, 0);
        send_pkt(6'd14, 16'hFF00, 0);
        expect_packet(6'd14, 16'hFF00, 2);
        check_rises("boundary", r0, 6);
    endtask

    task automatic test_saturation();
        logic [5:0] a;
        int r0;
        r0 = rises;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(15, 63));
            send_pkt(a, 16'($urandom), 0);
        end
        @(negedge i_clk);
        check_rises("saturation", r0, 0);
        check_err("saturation");
        vectors++;
        if (err_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL saturation_abs err_cnt got %0d want 255", err_cnt);
        end
    endtask

    task automatic test_slow_ack();
        send_pkt(6'd9, 16'h5AC3, 0);
        expect_packet(6'd9, 16'h5AC3, 7);
    endtask

    task automatic test_long_req();
        int r0;
        r0 = rises;
        send_pkt(6'd3, 16'h7E81, 10);
        expect_packet(6'd3, 16'h7E81, 0);
        repeat (3) @(negedge i_clk);
        check_rises("long_req", r0, 3);
    endtask

    task automatic test_reset_mid();
        int n;
        send_pkt(6'd7, 16'hBEEF, 0);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!snd0.req && n < 50) begin @(negedge i_clk); n++; end
            snd0.ack = 1'b1;
            if (k == 0) begin
                n = 0;
                while (snd0.req && n < 50) begin @(negedge i_clk); n++; end
                snd0.ack = 1'b0;
            end
        end
        #2 reset = 1'b0;
        #1 check_idle_outputs("reset_mid");
        @(negedge i_clk);
        snd0.ack = 1'b0;
        @(negedge i_clk);
        reset   = 1'b1;
        exp_err = 0;
        @(negedge i_clk);
        send_pkt(6'd12, 16'h2468, 0);
        expect_packet(6'd12, 16'h2468, 0);
    endtask

    task automatic test_random();
        logic [5:0]  a;
        logic [15:0] d;
        int r0;
        for (int p = 0; p < 1000; p++) begin
            a = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(1, 14)) : 6'($urandom_range(0, 63));
            d = 16'($urandom);
            r0 = rises;
            send_pkt(a, d, int'($urandom_range(0, 3)));
            if (legal(a)) expect_packet(a, d, int'($urandom_range(0, 3)));
            else repeat (3) @(negedge i_clk);
            check_rises("random", r0, legal(a) ? 3 : 0);
            check_err("random");
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_out_of_range();
        test_boundary();
        test_saturation();
        test_slow_ack();
        test_long_req();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pakout.md
Name: pakout

Overview:
- Packet serializer; the transmit-side counterpart of pakin.
- Accepts one whole packet (address plus PSZ data words) on a 4-phase req/ack receive channel.
- Emits the packet as a sequence of pakio beats on a 4-phase req/ack send channel: one address beat, then PSZ data beats.
- Sits between a cell's packet output and the inter-clock pakio link that feeds a remote pakin.

Parameters:
- PSZ, `NS_PACKET_SIZE: data words per packet, ≥1.
- ASZ, `NS_ADDRESS_SIZE: address width, ASZ ≤ DSZ.
- DSZ, `NS_DATA_SIZE: word width; must be a multiple of RSZ.
- RSZ, `NS_REDUN_SIZE: redundancy field width per beat.
- MIN_ADDR, 1: lowest legal destination address.
- MAX_ADDR, 14: highest legal destination address.

Ports:
- i_clk  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- ready  out  1  high when idle and able to accept a packet.
- rcv0_addr  in  ASZ  packet destination address.
- rcv0_dat  in  PSZ*DSZ  packet words; word k occupies bits [k*DSZ +: DSZ].
- rcv0_req  in  1  upstream request.
- rcv0_ack  out  1  acknowledge to upstream.
- snd0_dat  out  DSZ  beat payload.
- snd0_red  out  RSZ  beat redundancy.
- snd0_is_addr  out  1  marks the address beat.
- snd0_last  out  1  marks the final data beat.
- snd0_req  out  1  request to downstream pakin.
- snd0_ack  in  1  acknowledge from downstream.
- err_cnt  out  8  count of dropped out-of-range packets; saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0 except ready=1.
  - State goes to S_IDLE; beat index and latched packet are cleared.
- Handshakes: both channels use the 4-phase protocol. Data is stable while req is high. ack rises after capture. req falls, then ack falls. No new req is issued until the previous ack is low.
- All outputs are registered.
- S_IDLE:
  - ready=1.
  - On rcv0_req=1, latch rcv0_addr and rcv0_dat, set rcv0_ack=1 and ready=0, go to S_IN_REL.
- S_IN_REL:
  - Wait for rcv0_req=0, then drop rcv0_ack.
  - If MIN_ADDR ≤ addr ≤ MAX_ADDR: set idx=0 and go to S_OUT_REQ.
  - Otherwise: err_cnt+1 (saturate at 255), go to S_IDLE, emit no beats.
- S_OUT_REQ:
  - Drive the beat for idx and raise snd0_req.
  - idx=0: snd0_dat = addr zero-extended to DSZ; snd0_is_addr=1.
  - idx=k (1..PSZ): snd0_dat = word k-1; snd0_last = (k==PSZ).
  - Wait for snd0_ack=1, then go to S_OUT_REL.
- S_OUT_REL:
  - snd0_req=0; wait for snd0_ack=0.
  - If idx==PSZ: go to S_IDLE and clear is_addr/last.
  - Else idx+1 and go to S_OUT_REQ.
- Redundancy: snd0_red = XOR of the DSZ/RSZ RSZ-bit slices of snd0_dat. Computed combinationally from the next beat and registered together with snd0_dat.
- Beat count: exactly PSZ+1 beats per legal packet. idx width is clog2(PSZ+1).
- Minimum latency: rcv0_req rise to first snd0_req rise is 2 cycles, plus the wait for rcv0_req to fall.
- Boundary conditions:
  - rcv0_req is ignored outside S_IDLE.
  - snd0_ack is ignored outside S_OUT_REQ/S_OUT_REL.
  - A reset mid-packet aborts it with no partial beat completion. Downstream sees snd0_req drop asynchronously.
  - addr equal to MIN_ADDR or MAX_ADDR is legal.
  - err_cnt holds at 255.

Decomposition:
- Shared package/header (hglobal.v):
  - State encodings S_IDLE, S_IN_REL, S_OUT_REQ, S_OUT_REL.
  - Redundancy-fold macro, reused by pakin for checking.
  - Instantiation macros NS_INSTA_RCV_CHNL and NS_INSTA_SND_PAKIO_CHNL, used for port hookup.
- One natural sub-module: pakout_red (parameterised XOR fold, DSZ→RSZ), shared with pakin's checker.

Test Plan (PSZ=2, ASZ=6, DSZ=8, RSZ=4):
- Legal packet: addr=5, words 0x3C, 0xA1, downstream acks in 1 cycle.
  - Beats are (0x05, red 0x5, is_addr=1), (0x3C, red 0xF), (0xA1, red 0xB, last=1).
  - ready returns to 1 after the final ack falls.
- Out-of-range address: addr=0, then addr=15.
  - Zero snd0_req pulses; err_cnt=2; both upstream handshakes complete.
- Boundary addresses: addr=1 and addr=14 each produce 3 beats.
  - Saturation: 300 illegal packets → err_cnt=255.
- Slow or back-to-back traffic:
  - Downstream ack delayed 7 cycles per beat → snd0_dat and snd0_red stay stable while snd0_req=1.
  - Upstream rcv0_req held high 10 cycles → rcv0_ack stays high until req falls; no double capture.
- Reset mid-packet: reset=0 after beat 1 is acked.
  - All outputs clear immediately and ready=1.
  - A fresh packet afterwards starts from the address beat.
- Random: 1000 packets with random addr, data and delays, checked against a pakin scoreboard.
  - Zero mismatches.
  - Beat count is 3 per legal packet.
